video_overlay_gen: RTL and testbench

VIDEO_OVERLAY_GEN -- requirements
Module: video_overlay_gen

---
 rtl/video_overlay_gen.sv | 149 ++++++++++++++
 tb/tb_video_overlay_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_overlay_gen.sv
// Raster tracker for a composite video feed: synchronises sync/video, counts
// lines and columns, overlays a crosshair on the white gate and flags bright windows.
module video_overlay_gen #(
    parameter int CNT_W = 10,
    parameter int N_WIN = 2,
    parameter int ARM   = 8
) (
    input  logic                   clk4mhz,
    input  logic                   rst,
    input  logic                   csync,
    input  logic                   vsync,
    input  logic                   video,
    input  logic                   ch_en,
    input  logic [CNT_W-1:0]       ch_x,
    input  logic [CNT_W-1:0]       ch_y,
    input  logic [N_WIN*CNT_W-1:0] win_x0,
    input  logic [N_WIN*CNT_W-1:0] win_x1,
    input  logic [N_WIN*CNT_W-1:0] win_y0,
    input  logic [N_WIN*CNT_W-1:0] win_y1,
    output logic                   gate_w,
    output logic                   gate_b,
    output logic [CNT_W-1:0]       line_count,
    output logic [CNT_W-1:0]       column_count,
    output logic [N_WIN-1:0]       win_hit,
    output logic [N_WIN-1:0]       win_bright,
    output logic                   frame_start
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   ARM_LEN = (CNT_W+1)'(ARM);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : (v + CNT_ONE);
    endfunction

    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        logic [CNT_W:0] ea;
        logic [CNT_W:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

    // [1] of each chain is the synchronised copy used by all downstream logic
    logic [1:0]       csync_p0;
    logic [1:0]       vsync_p0;
    logic [1:0]       video_p0;
    logic             csync_prev;
    logic             vsync_prev;
    logic             csync_fall;
    logic             vsync_fall;

    logic [CNT_W-1:0] sh_x_p1;
    logic [CNT_W-1:0] sh_y_p1;
    logic             sh_en_p1;

    logic             video_p2;
    logic [N_WIN-1:0] acc_p2;
    logic [N_WIN-1:0] hit_now;
    logic             crosshair;
    logic [N_WIN-1:0] win_in;

    assign csync_fall = csync_prev & ~csync_p0[1];
    assign vsync_fall = vsync_prev & ~vsync_p0[1];
    assign hit_now    = win_hit & {N_WIN{video_p2}};

    always_comb begin
        crosshair = 1'b0;
        if (sh_en_p1) begin
            if (line_count == sh_y_p1 && abs_diff(column_count, sh_x_p1) <= ARM_LEN)
                crosshair = 1'b1;
            if (column_count == sh_x_p1 && abs_diff(line_count, sh_y_p1) <= ARM_LEN)
                crosshair = 1'b1;
        end
    end

    // Inverted bounds can never satisfy both inequalities, so they never hit
    always_comb begin
        win_in = '0;
        for (int k = 0; k < N_WIN; k++) begin
            win_in[k] = (column_count >= win_x0[k*CNT_W +: CNT_W]) &&
                        (column_count <= win_x1[k*CNT_W +: CNT_W]) &&
                        (line_count   >= win_y0[k*CNT_W +: CNT_W]) &&
                        (line_count   <= win_y1[k*CNT_W +: CNT_W]);
        end
    end

    always_ff @(posedge clk4mhz) begin
        if (rst) begin
            // sync lines idle high so release cannot look like a falling edge
            csync_p0     <= 2'b11;
            vsync_p0     <= 2'b11;
            video_p0     <= 2'b00;
            csync_prev   <= 1'b0;
            vsync_prev   <= 1'b0;
            line_count   <= '0;
            column_count <= '0;
            frame_start  <= 1'b0;
            sh_x_p1      <= '0;
            sh_y_p1      <= '0;
            sh_en_p1     <= 1'b0;
            gate_w       <= 1'b0;
            gate_b       <= 1'b1;
            win_hit      <= '0;
            video_p2     <= 1'b0;
            acc_p2       <= '0;
            win_bright   <= '0;
        end else begin
            // stage p0: synchronisers and edge history
            csync_p0   <= {csync_p0[0], csync};
            vsync_p0   <= {vsync_p0[0], vsync};
            video_p0   <= {video_p0[0], video};
            csync_prev <= csync_p0[1];
            vsync_prev <= vsync_p0[1];

            // stage p1: raster counters, frame pulse, crosshair shadows
            if (vsync_fall) begin
                line_count   <= '0;
                column_count <= csync_fall ? '0 : sat_inc(column_count);
            end else if (csync_fall) begin
                line_count   <= sat_inc(line_count);
                column_count <= '0;
            end else begin
                column_count <= sat_inc(column_count);
            end
            frame_start <= vsync_fall;
            if (frame_start) begin
                sh_x_p1  <= ch_x;
                sh_y_p1  <= ch_y;
                sh_en_p1 <= ch_en;
            end

            // stage p2: gates, window hits and per-frame brightness
            gate_b   <= ~video_p0[1];
            gate_w   <= ~video_p0[1] ^ crosshair;
            win_hit  <= win_in;
            video_p2 <= video_p0[1];
            if (frame_start) begin
                win_bright <= acc_p2;
                acc_p2     <= hit_now;
            end else begin
                acc_p2     <= acc_p2 | hit_now;
            end
        end
    end

endmodule

// File: tb/tb_video_overlay_gen.sv
// Directed bench for video_overlay_gen: queued expectations are compared
// against the DUT outputs on the cycle they fall due.
module tb_video_overlay_gen;

    localparam int CNT_W = 10;
    localparam int N_WIN = 2;
    localparam int ARM   = 8;
    localparam int P     = 130;

    localparam int S_LINE   = 0;
    localparam int S_COL    = 1;
    localparam int S_GW     = 2;
    localparam int S_GB     = 3;
    localparam int S_HIT    = 4;
    localparam int S_BRIGHT = 5;
    localparam int S_FS     = 6;

    logic                   clk4mhz = 1'b0;
    logic                   rst;
    logic                   csync;
    logic                   vsync;
    logic                   video;
    logic                   ch_en;
    logic [CNT_W-1:0]       ch_x;
    logic [CNT_W-1:0]       ch_y;
    logic [N_WIN*CNT_W-1:0] win_x0;
    logic [N_WIN*CNT_W-1:0] win_x1;
    logic [N_WIN*CNT_W-1:0] win_y0;
    logic [N_WIN*CNT_W-1:0] win_y1;
    logic                   gate_w;
    logic                   gate_b;
    logic [CNT_W-1:0]       line_count;
    logic [CNT_W-1:0]       column_count;
    logic [N_WIN-1:0]       win_hit;
    logic [N_WIN-1:0]       win_bright;
    logic                   frame_start;

    typedef struct {
        int          due;
        int          sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk4mhz = ~clk4mhz;

    video_overlay_gen #(
        .CNT_W(CNT_W),
        .N_WIN(N_WIN),
        .ARM  (ARM)
    ) dut (
        .clk4mhz     (clk4mhz),
        .rst         (rst),
        .csync       (csync),
        .vsync       (vsync),
        .video       (video),
        .ch_en       (ch_en),
        .ch_x        (ch_x),
        .ch_y        (ch_y),
        .win_x0      (win_x0),
        .win_x1      (win_x1),
        .win_y0      (win_y0),
        .win_y1      (win_y1),
        .gate_w      (gate_w),
        .gate_b      (gate_b),
        .line_count  (line_count),
        .column_count(column_count),
        .win_hit     (win_hit),
        .win_bright  (win_bright),
        .frame_start (frame_start)
    );

    function automatic logic [31:0] sample(input int sig);
        case (sig)
            S_LINE:   return 32'(line_count);
            S_COL:    return 32'(column_count);
            S_GW:     return 32'(gate_w);
            S_GB:     return 32'(gate_b);
            S_HIT:    return 32'(win_hit);
            S_BRIGHT: return 32'(win_bright);
            S_FS:     return 32'(frame_start);
            default:  return 'x;
        endcase
    endfunction

    // Crosshair footprint: horizontal arm on line y, vertical arm on column x
    function automatic bit in_cross(input int l, input int c, input int x,
                                    input int y, input bit en);
        return en && ((l == y && c >= x - ARM && c <= x + ARM) ||
                      (c == x && l >= y - ARM && l <= y + ARM));
    endfunction

    task automatic expect_at(input string tag, input int sig,
                             input logic [31:0] val, input int due);
        exp_t e;
        e.due = due;
        e.sig = sig;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_due();
        logic [31:0] obs;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                obs = sample(sb[i].sig);
                checks++;
                assert (obs === sb[i].val) else begin
                    errors++;
                    $error("FAIL %s: observed %0d expected %0d (cycle %0d)",
                           sb[i].tag, obs, sb[i].val, cyc);
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk4mhz);
        #1;
        cyc++;
        check_due();
    endtask

    // One raster line opened by a csync fall (with vsync when vs is set).
    // Pin driven at cycle n shows up on the counters at n+3; the pixel at
    // column c is reported on the gates/win_hit at n+4+c.
    task automatic run_line(input int l, input bit vs, input int vid_col,
                            input int sx, input int sy, input bit sen,
                            input logic [N_WIN-1:0] prev_acc);
        int n;
        int cols[$];
        int wcols[$];
        bit inwin;
        n = cyc;
        csync = 1'b0;
        if (vs) begin
            vsync = 1'b0;
            expect_at("fs_before", S_FS, 0, n + 2);
            expect_at("fs_pulse", S_FS, 1, n + 3);
            expect_at("fs_after", S_FS, 0, n + 4);
            expect_at("frame_line0", S_LINE, 0, n + 3);
            expect_at("frame_col0", S_COL, 0, n + 3);
            expect_at("win_bright", S_BRIGHT, 32'(prev_acc), n + 4);
        end else begin
            expect_at("line_inc", S_LINE, l, n + 3);
            expect_at("line_col0", S_COL, 0, n + 3);
        end

        cols = '{sx - 1, sx, sx + 1, 50, 100};
        if (l == sy) begin
            cols.push_back(sx - ARM - 1);
            cols.push_back(sx - ARM);
            cols.push_back(sx + ARM);
            cols.push_back(sx + ARM + 1);
        end
        foreach (cols[i])
            expect_at("cross_gate_w", S_GW, 32'(!in_cross(l, cols[i], sx, sy, sen)),
                      n + 4 + cols[i]);
        expect_at("idle_gate_b", S_GB, 1, n + 4 + sx);

        wcols = '{24, 25, 27, 30, 31};
        foreach (wcols[i]) begin
            inwin = (l >= 25 && l <= 30 && wcols[i] >= 25 && wcols[i] <= 30);
            expect_at("win_hit", S_HIT, 32'(inwin), n + 4 + wcols[i]);
        end

        if (vid_col >= 0) begin
            expect_at("video_gate_b", S_GB, 0, n + 4 + vid_col);
            expect_at("video_gate_w", S_GW, 32'(in_cross(l, vid_col, sx, sy, sen)),
                      n + 4 + vid_col);
            expect_at("video_gate_b_end", S_GB, 1, n + 5 + vid_col);
        end

        for (int i = 0; i < P; i++) begin
            tick();
            csync = 1'b1;
            vsync = 1'b1;
            video = (vid_col >= 0 && cyc == n + 1 + vid_col);
        end
    endtask

    task automatic run_frame(input int vid_line, input int sx, input int sy,
                             input bit sen, input logic [N_WIN-1:0] prev_acc,
                             input int last_line, input int chg_line,
                             input int chg_x, input bit chg_en);
        for (int l = 0; l <= last_line; l++) begin
            if (l == chg_line) begin
                ch_x  = CNT_W'(chg_x);
                ch_en = chg_en;
            end
            run_line(l, l == 0, (l == vid_line) ? 28 : -1, sx, sy, sen, prev_acc);
        end
    endtask

    initial begin
        int n;
        rst    = 1'b1;
        csync  = 1'b1;
        vsync  = 1'b1;
        video  = 1'b0;
        ch_en  = 1'b1;
        ch_x   = 10'd100;
        ch_y   = 10'd20;
        win_x0 = {10'd40, 10'd25};
        win_x1 = {10'd35, 10'd30};
        win_y0 = {10'd0, 10'd25};
        win_y1 = {10'd1023, 10'd30};

        repeat (3) tick();
        expect_at("reset_line", S_LINE, 0, cyc);
        expect_at("reset_col", S_COL, 0, cyc);
        expect_at("reset_gate_w", S_GW, 0, cyc);
        expect_at("reset_gate_b", S_GB, 1, cyc);
        expect_at("reset_win_hit", S_HIT, 0, cyc);
        expect_at("reset_win_bright", S_BRIGHT, 0, cyc);
        expect_at("reset_frame_start", S_FS, 0, cyc);
        check_due();
        rst = 1'b0;
        tick();

        n = cyc;
        csync = 1'b0;
        expect_at("first_line", S_LINE, 1, n + 3);
        tick();
        csync = 1'b1;
        repeat (20) tick();

        // vsync alone: frame pulse three cycles after the pin, line back to 0
        n = cyc;
        vsync = 1'b0;
        expect_at("vs_line_before", S_LINE, 1, n + 2);
        expect_at("vs_fs_before", S_FS, 0, n + 2);
        expect_at("vs_fs_pulse", S_FS, 1, n + 3);
        expect_at("vs_line0", S_LINE, 0, n + 3);
        expect_at("vs_fs_end", S_FS, 0, n + 4);
        tick();
        vsync = 1'b1;
        repeat (10) tick();

        // ten lines of 250 cycles, then a long line that must saturate
        for (int p = 0; p < 10; p++) begin
            n = cyc;
            csync = 1'b0;
            expect_at("cnt_line", S_LINE, p + 1, n + 3);
            expect_at("cnt_col_zero", S_COL, 0, n + 3);
            expect_at("cnt_col_end", S_COL, 249, n + 252);
            if (p == 9) begin
                expect_at("sat_col_1022", S_COL, 1022, n + 3 + 1022);
                expect_at("sat_col_1023", S_COL, 1023, n + 3 + 1023);
                expect_at("sat_col_hold", S_COL, 1023, n + 3 + 1800);
                expect_at("sat_line_hold", S_LINE, 10, n + 3 + 1800);
            end
            tick();
            csync = 1'b1;
            repeat (249) tick();
        end
        repeat (1900) tick();

        // frame A: simultaneous csync/vsync, crosshair at (100,20), ch_x moved mid-frame
        run_frame(27, 100, 20, 1'b1, 2'b00, 31, 5, 50, 1'b1);
        // frame B: new ch_x takes effect; enable dropped mid-frame
        run_frame(-1, 50, 20, 1'b1, 2'b01, 31, 5, 50, 1'b0);
        // frame C: crosshair off, bright pixel again
        run_frame(27, 50, 20, 1'b0, 2'b00, 31, -1, 50, 1'b0);
        // frame D: bright pixel, then reset before the frame ends
        run_frame(27, 50, 20, 1'b0, 2'b01, 27, -1, 50, 1'b0);

        n = cyc;
        rst = 1'b1;
        expect_at("midrst_line", S_LINE, 0, n + 1);
        expect_at("midrst_col", S_COL, 0, n + 1);
        expect_at("midrst_gate_w", S_GW, 0, n + 1);
        expect_at("midrst_gate_b", S_GB, 1, n + 1);
        expect_at("midrst_win_hit", S_HIT, 0, n + 1);
        expect_at("midrst_win_bright", S_BRIGHT, 0, n + 1);
        expect_at("midrst_frame_start", S_FS, 0, n + 1);
        for (int k = 2; k <= 40; k += 2)
            expect_at("no_spurious_fs", S_FS, 0, n + k);
        expect_at("post_rst_col", S_COL, 10, n + 11);
        expect_at("post_rst_bright", S_BRIGHT, 0, n + 40);
        tick();
        rst = 1'b0;
        repeat (44) tick();

        // frame E: abandoned frame D must not report its bright pixel
        run_frame(-1, 50, 20, 1'b0, 2'b00, 0, -1, 50, 1'b0);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
